// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator sequencing controller.
// Build option CALC_SEQ_SAT_EN (used by calc_seq_ctrl) selects saturation instead of wrap.
package calc_pkg;

  localparam int WIDTH = 8;

  localparam logic [2:0] OP_LOAD = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b001;
  localparam logic [2:0] OP_SUB  = 3'b010;
  localparam logic [2:0] OP_MUL  = 3'b011;
  localparam logic [2:0] OP_NEG  = 3'b100;
  localparam logic [2:0] OP_CLR  = 3'b101;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EXEC    = 2'd1,
    MUL_RUN = 2'd2,
    DONE    = 2'd3
  } state_e;

  localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

  typedef struct packed {
    logic [WIDTH-1:0] res;
    logic             ovf;
    logic             sign;
  } step_t;

  // Unsigned magnitude; -128 maps to 128, which still fits in WIDTH unsigned bits.
  function automatic logic [WIDTH-1:0] abs_mag(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? (~v + WIDTH'(1)) : v;
  endfunction

endpackage

// File: rtl/calc_step_alu.sv
// One signed add/sub step on sign-extended operands; shared by single-step ops
// and every multiply iteration.
module calc_step_alu
  import calc_pkg::*;
(
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             sub_i,
  output step_t            step_o
);

  logic [WIDTH:0] a_x;
  logic [WIDTH:0] b_x;
  logic [WIDTH:0] sum_x;

  // NOTE: every combinational output is assigned on every path, so no latch can be inferred.
  always_comb begin
    a_x         = {a_i[WIDTH-1], a_i};
    b_x         = {b_i[WIDTH-1], b_i};
    sum_x       = sub_i ? (a_x - b_x) : (a_x + b_x);
    step_o.res  = sum_x[WIDTH-1:0];
    step_o.ovf  = sum_x[WIDTH] ^ sum_x[WIDTH-1];
    step_o.sign = sum_x[WIDTH];
  end

endmodule

// File: rtl/calc_seq_ctrl.sv
// Command sequencer for the 8-bit signed calculator path: single-step ops plus
// iterated multiply. Define CALC_SEQ_SAT_EN to clamp overflowed results.
module calc_seq_ctrl #(
  parameter int WIDTH      = 8,
  parameter int STICKY_OVF = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             res_ovf,
  output logic             res_err,
  output logic [WIDTH-1:0] acc,
  output logic             acc_ovf,
  output logic             busy
);
  import calc_pkg::*;

  state_e           state_q;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] b_q, a_q, p_q, cnt_q;
  logic             mul_ovf_q;
  logic [WIDTH-1:0] acc_q, res_data_q;
  logic             acc_ovf_q, res_ovf_q, res_err_q;

  logic [WIDTH-1:0] alu_a, alu_b;
  logic             alu_sub;
  step_t            alu_out;

  logic [WIDTH-1:0] exec_data, mul_data;
  logic [WIDTH-1:0] fin_data_d;
  logic             fin_ovf_d, fin_err_d, acc_ovf_d;

  always_comb begin
    alu_a   = acc_q;
    alu_b   = b_q;
    alu_sub = 1'b0;
    if (state_q == MUL_RUN) begin
      alu_a   = p_q;
      alu_b   = a_q;
      alu_sub = b_q[WIDTH-1];
    end else begin
      case (op_q)
        OP_SUB: alu_sub = 1'b1;
        OP_NEG: begin
          alu_a   = '0;
          alu_b   = acc_q;
          alu_sub = 1'b1;
        end
        default: alu_sub = 1'b0;
      endcase
    end
  end

  calc_step_alu u_alu (
    .a_i   (alu_a),
    .b_i   (alu_b),
    .sub_i (alu_sub),
    .step_o(alu_out)
  );

`ifdef CALC_SEQ_SAT_EN
  // Multiply direction is the sign of a*b; a is nonzero whenever overflow occurred.
  assign exec_data = alu_out.ovf ? (alu_out.sign ? SMIN : SMAX) : alu_out.res;
  assign mul_data  = mul_ovf_q ? ((a_q[WIDTH-1] ^ b_q[WIDTH-1]) ? SMIN : SMAX) : p_q;
`else
  logic unused_sign;
  assign unused_sign = alu_out.sign;
  assign exec_data   = alu_out.res;
  assign mul_data    = p_q;
`endif

  always_comb begin
    fin_data_d = exec_data;
    fin_ovf_d  = alu_out.ovf;
    fin_err_d  = 1'b0;
    if (state_q == MUL_RUN) begin
      fin_data_d = mul_data;
      fin_ovf_d  = mul_ovf_q;
    end else begin
      case (op_q)
        OP_LOAD: begin
          fin_data_d = b_q;
          fin_ovf_d  = 1'b0;
        end
        OP_ADD, OP_SUB, OP_NEG: begin
          fin_data_d = exec_data;
          fin_ovf_d  = alu_out.ovf;
        end
        OP_MUL, OP_CLR: begin
          fin_data_d = '0;
          fin_ovf_d  = 1'b0;
        end
        default: begin
          fin_data_d = acc_q;
          fin_ovf_d  = 1'b0;
          fin_err_d  = 1'b1;
        end
      endcase
    end

    if (op_q == OP_LOAD || op_q == OP_CLR) acc_ovf_d = 1'b0;
    else if (STICKY_OVF != 0)              acc_ovf_d = acc_ovf_q | fin_ovf_d;
    else                                   acc_ovf_d = fin_ovf_d;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      op_q       <= OP_LOAD;
      b_q        <= '0;
      a_q        <= '0;
      p_q        <= '0;
      cnt_q      <= '0;
      mul_ovf_q  <= 1'b0;
      acc_q      <= '0;
      acc_ovf_q  <= 1'b0;
      res_data_q <= '0;
      res_ovf_q  <= 1'b0;
      res_err_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            op_q      <= cmd_op;
            b_q       <= cmd_data;
            a_q       <= acc_q;
            p_q       <= '0;
            cnt_q     <= abs_mag(cmd_data);
            mul_ovf_q <= 1'b0;
            state_q   <= (cmd_op == OP_MUL && cmd_data != '0) ? MUL_RUN : EXEC;
          end
        end
        EXEC, MUL_RUN: begin
          if (state_q == MUL_RUN && cnt_q != '0) begin
            p_q       <= alu_out.res;
            mul_ovf_q <= mul_ovf_q | alu_out.ovf;
            cnt_q     <= cnt_q - WIDTH'(1);
          end else begin
            res_data_q <= fin_data_d;
            res_ovf_q  <= fin_ovf_d;
            res_err_q  <= fin_err_d;
            if (!fin_err_d) begin
              acc_q     <= fin_data_d;
              acc_ovf_q <= acc_ovf_d;
            end
            state_q <= DONE;
          end
        end
        DONE: begin
          if (res_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cmd_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign res_valid = (state_q == DONE);
  assign res_data  = res_data_q;
  assign res_ovf   = res_ovf_q;
  assign res_err   = res_err_q;
  assign acc       = acc_q;
  assign acc_ovf   = acc_ovf_q;

endmodule
